// File: rtl/pipe_credit_sink.sv
// pipe_credit_sink: credit-based sink for a valid-only pipeline with no backpressure.
//
// The producer may launch one item per cycle while a credit is available. Each
// launched item reserves one FIFO slot. The pipeline's final stage writes its result
// into the FIFO, and each pop returns one credit. This guarantees that a
// well-behaved producer can never overflow the FIFO.
//
// Parameters
//   DATA_WIDTH  width of the result word
//   DEPTH       number of FIFO entries (2..64; need not be a power of 2)
//
// Ports
//   clk          sole clock
//   rst          synchronous active-low reset
//   issue_valid  producer wants to launch an item
//   issue_ready  credit available; launch permitted this cycle
//   pipe_valid   final-stage valid of the pipeline (push into FIFO)
//   pipe_data    final-stage result word
//   out_valid    FIFO head valid
//   out_data     FIFO head word
//   out_ready    consumer accepts the head
//   err          sticky protocol-violation flag
//
// Build option
//   PIPE_CREDIT_SINK_CHECK_EN  when defined, track in-flight items and raise err on
//                              drops, unexpected arrivals, or requests with no credit.
//                              When undefined, err is tied to 0.

module pipe_credit_sink #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] OneC    = CW'(1);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic issue_fire;
    logic push;
    logic pop;
    logic push_ok;

    // Modulo-DEPTH increment, correct for non-power-of-2 depths.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    // Gated by rst so both read 0 while reset is held, even though the counters
    // already hold their reset values after the first reset edge.
    assign issue_ready = rst & (credits_q != '0);
    assign out_valid   = rst & (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];

    always_comb begin
        issue_fire = issue_valid & issue_ready;
        push       = pipe_valid;
        pop        = out_valid & out_ready;
        // When full, a push is accepted only if a pop frees the slot in the same cycle.
        push_ok    = push & ((count_q != DepthC) | pop);

        credits_d = credits_q;
        if (issue_fire && !pop) begin
            credits_d = credits_q - OneC;
        end else if (pop && !issue_fire && (credits_q != DepthC)) begin
            // Saturate so a rogue push cannot inflate credits past DEPTH.
            credits_d = credits_q + OneC;
        end

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + OneC;
            2'b01:   count_d = count_q - OneC;
            default: count_d = count_q;
        endcase

        wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits_q <= DepthC;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

`ifdef PIPE_CREDIT_SINK_CHECK_EN
    logic [CW-1:0] inflight_q, inflight_d;
    logic          err_q;
    logic          violation;

    always_comb begin
        inflight_d = inflight_q;
        if (issue_fire && !push && (inflight_q != DepthC)) begin
            inflight_d = inflight_q + OneC;
        end else if (push && !issue_fire && (inflight_q != '0)) begin
            inflight_d = inflight_q - OneC;
        end

        // An item issued this cycle cannot arrive this cycle, so a push with
        // nothing in flight is a violation even alongside a fire.
        violation = (push & ~push_ok)
                  | (push & (inflight_q == '0))
                  | (issue_valid & (credits_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (violation) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Directed bench for pipe_credit_sink (DEPTH=4) behind a 3-stage valid-only pipeline.
// Pipeline result word = 0xA0 + number of arrivals since reset.

module tb_pipe_credit_sink;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
`ifdef PIPE_CREDIT_SINK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic          pipe_valid;
    logic [DW-1:0] pipe_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          err;

    logic          force_pv;
    logic [2:0]    stage   = '0;
    logic [31:0]   arr_cnt = '0;
    int            fires   = 0;
    int            total   = 0;
    int            bad     = 0;

    pipe_credit_sink #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Latency-3 pipeline model sharing the sink's reset.
    always @(posedge clk) begin
        if (!rst) begin
            stage   <= '0;
            arr_cnt <= '0;
            fires   <= 0;
        end else begin
            stage <= {stage[1:0], issue_valid & issue_ready};
            if (issue_valid && issue_ready) fires <= fires + 1;
            if (pipe_valid) arr_cnt <= arr_cnt + 32'd1;
        end
    end

    assign pipe_valid = stage[2] | force_pv;
    assign pipe_data  = 32'hA0 + arr_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] burst_ready;
        burst_ready = 6'b000111;  // bit i = expected issue_ready after burst edge i+1

        rst         = 1'b0;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        force_pv    = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);

        // Reset release.
        rst = 1'b1;
        tick();
        chk("rel_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_credits", 32'(dut.credits_q), 32'd4);
        chk("rel_err", {31'd0, err}, 32'd0);

        // Back-to-back burst with consumer stalled: only 4 fires.
        issue_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("burst_ready", {31'd0, issue_ready}, {31'd0, burst_ready[i]});
            if (i == 3) begin
                chk("burst_first_valid", {31'd0, out_valid}, 32'd1);
                chk("burst_first_data", out_data, 32'hA0);
            end
        end
        issue_valid = 1'b0;
        chk("burst_fires", 32'(fires), 32'd4);
        tick();
        chk("burst_count", 32'(dut.count_q), 32'd4);
        chk("burst_credits", 32'(dut.credits_q), 32'd0);
        chk("burst_hold_data", out_data, 32'hA0);
        chk("burst_err", {31'd0, err}, {31'd0, CHK});

        // Drain in order; credit returns the cycle after the first pop.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_head", out_data, 32'hA1 + 32'(i));
            if (i == 0) chk("drain_ready_rise", {31'd0, issue_ready}, 32'd1);
        end
        tick();
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("drain_credits", 32'(dut.credits_q), 32'd4);

        // Refill to full: words 0xA4..0xA7.
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("full_count", 32'(dut.count_q), 32'd4);
        chk("full_credits", 32'(dut.credits_q), 32'd0);
        chk("full_head", out_data, 32'hA4);

        // Push into a full FIFO with no pop: 0xA8 is dropped.
        force_pv = 1'b1;
        tick();
        chk("drop_count", 32'(dut.count_q), 32'd4);
        chk("drop_head", out_data, 32'hA4);
        chk("drop_err", {31'd0, err}, {31'd0, CHK});

        // Push with pop while full: 0xA9 accepted, count stays 4, credits 0 -> 1.
        out_ready = 1'b1;
        tick();
        force_pv = 1'b0;
        chk("simul_count", 32'(dut.count_q), 32'd4);
        chk("simul_credits", 32'(dut.credits_q), 32'd1);
        chk("simul_ready", {31'd0, issue_ready}, 32'd1);
        chk("simul_head", out_data, 32'hA5);
        tick();
        chk("order_head0", out_data, 32'hA6);
        tick();
        chk("order_head1", out_data, 32'hA7);
        tick();
        chk("order_head2", out_data, 32'hA9);
        tick();
        chk("order_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-operation: count 3 with one item in flight.
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        issue_valid = 1'b0;
        tick();
        tick();
        chk("mid_count", 32'(dut.count_q), 32'd3);
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_credits", 32'(dut.credits_q), 32'd4);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_after_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_after_ready", {31'd0, issue_ready}, 32'd1);

        // Unexpected arrival with nothing issued.
        force_pv = 1'b1;
        tick();
        force_pv = 1'b0;
        chk("viol_err", {31'd0, err}, {31'd0, CHK});
        chk("viol_data", out_data, 32'hA0);
        tick();
        chk("viol_err_sticky1", {31'd0, err}, {31'd0, CHK});
        tick();
        chk("viol_err_sticky2", {31'd0, err}, {31'd0, CHK});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_credit_sink.md
PIPE_CREDIT_SINK -- requirements
Module: pipe_credit_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the pipeline result word.
REQ-002 SHALL have parameter DEPTH, default 4, number of output FIFO entries (legal range 2..64).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset (0 = reset, 1 = run).
REQ-005 SHALL have port issue_valid, input, 1, producer requests to launch one item into the valid-only pipeline.
REQ-006 SHALL have port issue_ready, output, 1, a credit is available, so a launch this cycle is permitted.
REQ-007 SHALL have port pipe_valid, input, 1, the pipeline's final-stage valid bit.
REQ-008 SHALL have port pipe_data, input, DATA_WIDTH, the pipeline's final-stage result register.
REQ-009 SHALL have port out_valid, output, 1, the FIFO head is valid.
REQ-010 SHALL have port out_data, output, DATA_WIDTH, the FIFO head word.
REQ-011 SHALL have port out_ready, input, 1, the downstream consumer accepts the head.
REQ-012 SHALL have port err, output, 1, sticky protocol-violation flag (see Configuration).

Function
REQ-013 SHALL define issue_fire = issue_valid & issue_ready, push = pipe_valid, and pop = out_valid & out_ready.
REQ-014 SHALL hold a credit counter of width $clog2(DEPTH+1) that resets to DEPTH and updates as credits - issue_fire + pop each cycle.
REQ-015 SHALL drive issue_ready = (credits != 0), combinationally from the registered counter only, with no path from issue_valid.
REQ-016 SHALL treat issue_fire and pop in the same cycle as leaving credits unchanged, including at credits == 0 and credits == DEPTH.
REQ-017 SHALL write pipe_data into the FIFO tail on push, with no dependence on out_ready, because the pipeline has no backpressure.
REQ-018 SHALL accept a push when count < DEPTH, or when count == DEPTH and pop occurs in the same cycle; count is then unchanged.
REQ-019 SHALL drop a push that arrives when count == DEPTH without a pop, leaving FIFO contents unchanged.
REQ-020 SHALL drive out_valid = (count != 0) and out_data = the head entry, both from registered state only.
REQ-021 SHALL have a latency of 1 cycle: a push in cycle N makes the word visible on out_data in cycle N+1 when the FIFO was empty.
REQ-022 SHALL keep out_data stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL implement the read and write pointers as modulo-DEPTH counters that wrap correctly for non-power-of-2 DEPTH, and SHALL hold count in the range 0..DEPTH.
REQ-024 SHALL preserve strict FIFO order; the Nth pushed word is the Nth popped word.
REQ-025 SHALL ensure that credits + count + in-flight items == DEPTH whenever the producer obeys issue_ready and the pipeline conserves items.

Reset
REQ-026 SHALL, on any clk edge with rst == 0, set credits = DEPTH, count = 0, both pointers = 0, err = 0 and in-flight = 0.
REQ-027 SHALL, during reset, drive out_valid = 0 and issue_ready = 0, and SHALL leave FIFO storage contents don't-care.
REQ-028 SHALL, on reset asserted mid-operation, discard all buffered and in-flight items; the pipeline shares rst, so its valid bits are also cleared.

Configuration
REQ-029 SHALL recognise the macro PIPE_CREDIT_SINK_CHECK_EN.
REQ-030 SHALL, when PIPE_CREDIT_SINK_CHECK_EN is defined, track in-flight = issued minus arrived items and set err sticky on any of the following:
- a push that is dropped per REQ-019;
- push while in-flight == 0;
- issue_valid while credits == 0.
REQ-031 SHALL, when PIPE_CREDIT_SINK_CHECK_EN is defined, keep err set until reset.
REQ-032 SHALL, when PIPE_CREDIT_SINK_CHECK_EN is undefined, omit the in-flight counter and tie err to 0; all other behaviour is identical.

Verification (DEPTH=4, pipeline latency 3)
REQ-033 SHALL cover reset release: after rst 0->1, issue_ready = 1, out_valid = 0, credits = 4 and err = 0.
REQ-034 SHALL cover a back-to-back burst: with out_ready = 0, issue 6 cycles of issue_valid = 1 -> exactly 4 fires, then issue_ready = 0; 4 pushes arrive 3 cycles after each fire; count = 4 and no drop occurs.
REQ-035 SHALL cover draining: from the full state, hold out_ready = 1 -> pops return 0xA0, 0xA1, 0xA2, 0xA3 in order, and issue_ready rises in the cycle after the first pop.
REQ-036 SHALL cover simultaneous events: count = 4, credits = 0, push with pop in the same cycle -> push is accepted, count stays 4, and credits go to 1.
REQ-037 SHALL cover the violation check: with the macro on, force pipe_valid = 1 with no prior issue -> err = 1 the next cycle and remains 1; with the macro off, err = 0 throughout.
REQ-038 SHALL cover reset mid-operation: with count = 3 and 1 item in flight, pulse rst = 0 for one cycle -> out_valid = 0, credits = 4 and err = 0 the next cycle.
